decodificador_n_seq: RTL and testbench
======================================

// Module: decodificador_n_seq
// PURPOSE
//   Parametrised, registered N-to-2^N one-hot decoder with a request handshake and three modes:
//   - DIRETO: held decode.
//   - PULSO: timed strobe.
//   - VARREDURA: walking one-hot scan.
//   Drives register-bank write strobes and ULA operation selects from a binary code.
// PARAMETERS
//   N          2  width of input code; output width M = 2**N (localparam)
//   LARG_PULSO 1  strobe length in cycles for PULSO mode (>=1)
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   A        in   N      binary code to decode
//   modo     in   2      00 DIRETO, 01 PULSO, 10 VARREDURA, 11 reserved
//   en       in   1      request valid; accepted when en && pronto
//   limpa    in   1      synchronous clear/abort
//   pronto   out  1      ready to accept a request
//   Y        out  M      registered one-hot (or all-zero) output
//   Y_valido out  1      1 whenever Y != 0
//   erro     out  1      1-cycle pulse on accepted request with modo=11
// BEHAVIOUR
//   Reset (rst_n=0, async): Y=0, Y_valido=0, erro=0, pronto=1, state OCIOSO, counters 0.
//   FSM states: OCIOSO, PULSO, VARRE. pronto=1 only in OCIOSO.
//   Accept: en && pronto at edge k; Y updates at edge k (visible cycle k+1). Latency 1.
//   Input capture:
//     - A and modo are sampled only on accept.
//     - Requests while pronto=0 are dropped, not queued.
//   DIRETO:
//     - Y = 1<<A; stay OCIOSO.
//     - Y held until the next accepted request or limpa.
//   PULSO:
//     - Y = 1<<A for exactly LARG_PULSO cycles, then Y=0 and return to OCIOSO.
//     - Down-counter width is clog2(LARG_PULSO+1).
//     - pronto rises in the same cycle Y returns to 0.
//   VARREDURA:
//     - Y = 1<<A, then rotates left by 1 each cycle, wrapping bit M-1 -> bit 0.
//     - After M one-hot cycles Y=0 and return to OCIOSO.
//     - Example, N=2, A=3: 1000, 0001, 0010, 0100, 0000.
//   modo=11 on accept: Y=0, erro=1 for one cycle, stay OCIOSO.
//   limpa=1 at an edge:
//     - Y=0, counters 0, state OCIOSO, erro=0.
//     - Wins over a simultaneous en; that request is not accepted.
//   Back-to-back DIRETO: a new accept replaces Y in one cycle; never two bits set.
//   Invariant: Y is always zero or one-hot. Y_valido = |Y is combinational from the register.
//   rst_n asserted mid-PULSO or mid-VARREDURA: immediate abort to reset values. No resume.
// STRUCTURE
//   Shared header decod_defs.vh:
//     - modo codes MODO_DIRETO/PULSO/VARRE/RES.
//     - state encodings EST_OCIOSO/PULSO/VARRE.
//   Sub-module decodificador_n_comb (N param, purely combinational A -> one-hot M):
//     - Provides the load value.
//     - Rotation and counters live in the top-level.
//   Scan counter width N+1 (counts M steps).
// TESTING
//   1. Reset: rst_n=0 -> Y=0, pronto=1, Y_valido=0, erro=0.
//      Release, idle 5 cycles -> no change.
//   2. DIRETO, N=2: A=2, en=1 -> next cycle Y=0100, stays 0100.
//      Then A=1 accepted -> Y=0010; limpa -> Y=0.
//   3. PULSO, LARG_PULSO=3: A=0 -> Y=0001 for 3 cycles, pronto=0 during them, then Y=0, pronto=1.
//      en during the busy cycles is ignored.
//   4. VARREDURA, N=3: A=6 -> Y=0x40,0x80,0x01,...,0x20 (8 cycles), then 0.
//      limpa at step 4 -> Y=0 next cycle.
//   5. modo=11, en=1 -> erro=1 one cycle, Y=0. limpa && en same edge -> not accepted, Y=0.
//   6. rst_n low mid-scan (async, between edges) -> Y=0 immediately.
//      Random regression: assert $onehot0(Y) every cycle.

Source files
------------

// File: rtl/decodificador_n_seq_pkg.sv
// Shared definitions for the sequential one-hot decoder: mode codes and FSM state encodings.
package decodificador_n_seq_pkg;

  typedef enum logic [1:0] {
    MODO_DIRETO = 2'b00,
    MODO_PULSO  = 2'b01,
    MODO_VARRE  = 2'b10,
    MODO_RES    = 2'b11
  } modo_e;

  typedef enum logic [1:0] {
    EST_OCIOSO = 2'b00,
    EST_PULSO  = 2'b01,
    EST_VARRE  = 2'b10
  } estado_e;

endpackage

// File: rtl/decodificador_n_comb.sv
// Purely combinational N-to-2^N one-hot decoder; supplies the load value for the sequencer.
module decodificador_n_comb #(
  parameter int N = 2
) (
  input  logic [N-1:0]      A,
  output logic [(2**N)-1:0] Y
);

  // Set exactly the bit addressed by A.
  always_comb begin
    Y    = {(2**N){1'b0}};
    Y[A] = 1'b1;
  end

endmodule

// File: rtl/decodificador_n_seq.sv
// Registered one-hot decoder with request handshake and held, timed-strobe and walking-scan modes.
module decodificador_n_seq
  import decodificador_n_seq_pkg::*;
#(
  parameter int N          = 2,
  parameter int LARG_PULSO = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       A,
  input  logic [1:0]         modo,
  input  logic               en,
  input  logic               limpa,
  output logic               pronto,
  output logic [(2**N)-1:0]  Y,
  output logic               Y_valido,
  output logic               erro
);

  localparam int M    = 2**N;
  localparam int CP_W = $clog2(LARG_PULSO + 1);
  localparam int CV_W = N + 1;

  estado_e          est_r, est_nxt_s;
  logic [M-1:0]     y_r, y_nxt_s, carga_s;
  logic             erro_r, erro_nxt_s;
  logic             pronto_r, pronto_nxt_s;
  logic [CP_W-1:0]  cnt_pulso_r, cnt_pulso_nxt_s;
  logic [CV_W-1:0]  cnt_varre_r, cnt_varre_nxt_s;

  decodificador_n_comb #(.N(N)) u_comb (
    .A (A),
    .Y (carga_s)
  );

  // Next-state and output computation; limpa overrides any request or activity.
  always_comb begin
    est_nxt_s       = est_r;
    y_nxt_s         = y_r;
    erro_nxt_s      = 1'b0;
    cnt_pulso_nxt_s = cnt_pulso_r;
    cnt_varre_nxt_s = cnt_varre_r;
    if (limpa) begin
      est_nxt_s       = EST_OCIOSO;
      y_nxt_s         = {M{1'b0}};
      cnt_pulso_nxt_s = {CP_W{1'b0}};
      cnt_varre_nxt_s = {CV_W{1'b0}};
    end else begin
      case (est_r)
        EST_OCIOSO: begin
          if (en) begin
            case (modo_e'(modo))
              MODO_DIRETO: begin
                y_nxt_s = carga_s;
              end
              MODO_PULSO: begin
                // Loaded with LARG_PULSO-1 so Y stays high for exactly LARG_PULSO cycles.
                y_nxt_s         = carga_s;
                cnt_pulso_nxt_s = CP_W'(LARG_PULSO - 1);
                est_nxt_s       = EST_PULSO;
              end
              MODO_VARRE: begin
                y_nxt_s         = carga_s;
                cnt_varre_nxt_s = CV_W'(M - 1);
                est_nxt_s       = EST_VARRE;
              end
              default: begin
                y_nxt_s    = {M{1'b0}};
                erro_nxt_s = 1'b1;
              end
            endcase
          end else begin
            y_nxt_s = y_r;
          end
        end
        EST_PULSO: begin
          if (cnt_pulso_r == {CP_W{1'b0}}) begin
            y_nxt_s   = {M{1'b0}};
            est_nxt_s = EST_OCIOSO;
          end else begin
            cnt_pulso_nxt_s = cnt_pulso_r - CP_W'(1);
          end
        end
        EST_VARRE: begin
          if (cnt_varre_r == {CV_W{1'b0}}) begin
            y_nxt_s   = {M{1'b0}};
            est_nxt_s = EST_OCIOSO;
          end else begin
            y_nxt_s         = {y_r[M-2:0], y_r[M-1]};
            cnt_varre_nxt_s = cnt_varre_r - CV_W'(1);
          end
        end
        default: begin
          est_nxt_s       = EST_OCIOSO;
          y_nxt_s         = {M{1'b0}};
          cnt_pulso_nxt_s = {CP_W{1'b0}};
          cnt_varre_nxt_s = {CV_W{1'b0}};
        end
      endcase
    end
    pronto_nxt_s = (est_nxt_s == EST_OCIOSO);
  end

  // State, output and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_r       <= EST_OCIOSO;
      y_r         <= {M{1'b0}};
      erro_r      <= 1'b0;
      pronto_r    <= 1'b1;
      cnt_pulso_r <= {CP_W{1'b0}};
      cnt_varre_r <= {CV_W{1'b0}};
    end else begin
      est_r       <= est_nxt_s;
      y_r         <= y_nxt_s;
      erro_r      <= erro_nxt_s;
      pronto_r    <= pronto_nxt_s;
      cnt_pulso_r <= cnt_pulso_nxt_s;
      cnt_varre_r <= cnt_varre_nxt_s;
    end
  end

  assign Y        = y_r;
  assign Y_valido = |y_r;
  assign erro     = erro_r;
  assign pronto   = pronto_r;

endmodule

// File: tb/tb_decodificador_n_seq.sv
// Self-checking bench for decodificador_n_seq (N=3, LARG_PULSO=3): vector table plus corner sequences.
module tb_decodificador_n_seq;

  localparam int N  = 3;
  localparam int LP = 3;
  localparam int M  = 2**N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  A;
  logic [1:0]    modo;
  logic          en;
  logic          limpa;
  logic          pronto;
  logic [M-1:0]  Y;
  logic          Y_valido;
  logic          erro;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         en;
    logic [N-1:0] a;
    logic [1:0]   modo;
    logic         limpa;
    logic [M-1:0] y;
    logic         pronto;
    logic         erro;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  decodificador_n_seq #(.N(N), .LARG_PULSO(LP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .modo     (modo),
    .en       (en),
    .limpa    (limpa),
    .pronto   (pronto),
    .Y        (Y),
    .Y_valido (Y_valido),
    .erro     (erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic e, input int a, input logic [1:0] m, input logic l,
                     input int y, input logic p, input logic er);
    vec_t v;
    v.en = e; v.a = N'(a); v.modo = m; v.limpa = l;
    v.y = M'(y); v.pronto = p; v.erro = er;
    vecs.push_back(v);
  endtask

  // Drive one vector, queue its expectation, and compare once the edge has produced output.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    en = v.en; A = v.a; modo = v.modo; limpa = v.limpa;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("vec%0d_Y", idx), 32'(Y), 32'(e.y));
    chk($sformatf("vec%0d_pronto", idx), 32'(pronto), 32'(e.pronto));
    chk($sformatf("vec%0d_erro", idx), 32'(erro), 32'(e.erro));
    chk($sformatf("vec%0d_Y_valido", idx), 32'(Y_valido), 32'(e.y != '0));
  endtask

  task automatic idle_inputs();
    en = 1'b0; A = '0; modo = 2'b00; limpa = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_Y", 32'(Y), 32'h0);
    chk("rst_pronto", 32'(pronto), 32'h1);
    chk("rst_Y_valido", 32'(Y_valido), 32'h0);
    chk("rst_erro", 32'(erro), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle%0d_Y", i), 32'(Y), 32'h0);
      chk($sformatf("idle%0d_pronto", i), 32'(pronto), 32'h1);
    end

    // DIRETO: held decode, replace, clear, back-to-back
    add(1, 2, 2'b00, 0, 'h04, 1, 0);
    add(0, 0, 2'b00, 0, 'h04, 1, 0);
    add(0, 0, 2'b00, 0, 'h04, 1, 0);
    add(1, 1, 2'b00, 0, 'h02, 1, 0);
    add(0, 0, 2'b00, 1, 'h00, 1, 0);
    add(1, 5, 2'b00, 0, 'h20, 1, 0);
    add(1, 7, 2'b00, 0, 'h80, 1, 0);
    add(0, 0, 2'b00, 1, 'h00, 1, 0);
    // PULSO, 3 cycles, requests while busy dropped
    add(1, 0, 2'b01, 0, 'h01, 0, 0);
    add(1, 4, 2'b00, 0, 'h01, 0, 0);
    add(1, 4, 2'b00, 0, 'h01, 0, 0);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    // VARREDURA from A=6 with wrap
    add(1, 6, 2'b10, 0, 'h40, 0, 0);
    add(1, 2, 2'b00, 0, 'h80, 0, 0);
    add(0, 0, 2'b00, 0, 'h01, 0, 0);
    add(0, 0, 2'b00, 0, 'h02, 0, 0);
    add(0, 0, 2'b00, 0, 'h04, 0, 0);
    add(0, 0, 2'b00, 0, 'h08, 0, 0);
    add(0, 0, 2'b00, 0, 'h10, 0, 0);
    add(0, 0, 2'b00, 0, 'h20, 0, 0);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    // VARREDURA aborted by limpa at step 4
    add(1, 6, 2'b10, 0, 'h40, 0, 0);
    add(0, 0, 2'b00, 0, 'h80, 0, 0);
    add(0, 0, 2'b00, 0, 'h01, 0, 0);
    add(0, 0, 2'b00, 0, 'h02, 0, 0);
    add(0, 0, 2'b00, 1, 'h00, 1, 0);
    // Reserved mode
    add(1, 3, 2'b11, 0, 'h00, 1, 1);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    add(1, 3, 2'b00, 0, 'h08, 1, 0);
    add(1, 0, 2'b11, 0, 'h00, 1, 1);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    // limpa wins over en
    add(1, 5, 2'b00, 1, 'h00, 1, 0);
    add(1, 2, 2'b01, 1, 'h00, 1, 0);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);
    // limpa mid-pulse
    add(1, 7, 2'b01, 0, 'h80, 0, 0);
    add(0, 0, 2'b00, 1, 'h00, 1, 0);
    add(1, 1, 2'b01, 0, 'h02, 0, 0);
    add(0, 0, 2'b00, 0, 'h02, 0, 0);
    add(0, 0, 2'b00, 0, 'h02, 0, 0);
    add(0, 0, 2'b00, 0, 'h00, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset between edges in the middle of a scan
    @(negedge clk);
    en = 1'b1; A = 3'd2; modo = 2'b10; limpa = 1'b0;
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("scan_before_rst_Y", 32'(Y), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_Y", 32'(Y), 32'h0);
    chk("async_rst_pronto", 32'(pronto), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume_Y", 32'(Y), 32'h0);

    // Random regression: Y must always be zero or one-hot
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      en    = 1'($urandom_range(0, 1));
      A     = N'($urandom_range(0, M - 1));
      modo  = 2'($urandom_range(0, 3));
      limpa = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d_onehot0", c), 32'($onehot0(Y)), 32'h1);
      chk($sformatf("rand%0d_valido", c), 32'(Y_valido), 32'(|Y));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
